// File: rtl/turbo_dispatch_sched.sv
`default_nettype none
// ============================================================================
// Module   : turbo_dispatch_sched
// Purpose  : Round-robin scheduler granting whole packets to free turbo lanes.
//            Optional statistics counters enabled by TURBO_SCHED_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module turbo_dispatch_sched #(
    parameter int NUM_TURBO     = 16,
    parameter int IDX_W         = 4,
    parameter int BUS           = 534,
    parameter int BEATS_PER_PKT = 25
) (
    input  logic                 clk_bus,
    input  logic                 rst_n,
    input  logic [BUS-1:0]       in_data,
    input  logic                 in_en,
    output logic                 bus_ready,
    output logic [BUS-1:0]       lane_data,
    output logic [NUM_TURBO-1:0] lane_en,
    input  logic [NUM_TURBO-1:0] lane_ready,
    input  logic [NUM_TURBO-1:0] lane_done,
    output logic [IDX_W-1:0]     cur_lane,
    output logic [NUM_TURBO-1:0] lane_busy,
    output logic [1:0]           err_flags
`ifdef TURBO_SCHED_STATS_EN
    ,
    output logic [31:0]          pkt_cnt,
    output logic [31:0]          stall_cnt
`endif
);

    localparam int                CNT_W  = $clog2(BEATS_PER_PKT);
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(BEATS_PER_PKT - 1);

    typedef enum logic [0:0] {
        SEL  = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_bus_ready;
    logic                   w_bus_ready_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [IDX_W-1:0]       r_rr;
    logic [IDX_W-1:0]       w_rr_nxt;
    logic [IDX_W-1:0]       r_cur_lane;
    logic [IDX_W-1:0]       w_cur_nxt;
    logic [NUM_TURBO-1:0]   r_busy;
    logic [NUM_TURBO-1:0]   w_set_busy;
    logic [NUM_TURBO-1:0]   r_lane_en;
    logic [BUS-1:0]         r_lane_data;
    logic [1:0]             r_err;
    logic                   w_found;
    logic [IDX_W-1:0]       w_grant;
    logic [IDX_W-1:0]       w_scan;
    logic                   w_beat;
    logic                   w_pkt_done;
    logic                   w_stall;

    // Scan starts just after the last grant; registered busy keeps same-cycle frees ineligible.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_scan  = '0;
        for (int k = 1; k <= NUM_TURBO; k++) begin
            w_scan = IDX_W'((int'(r_rr) + k) % NUM_TURBO);
            if (!w_found && lane_ready[w_scan] && !r_busy[w_scan]) begin
                w_found = 1'b1;
                w_grant = w_scan;
            end
        end
    end

    assign w_beat = in_en & r_bus_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_bus_ready_nxt = r_bus_ready;
        w_cnt_nxt       = r_cnt;
        w_rr_nxt        = r_rr;
        w_cur_nxt       = r_cur_lane;
        w_set_busy      = '0;
        w_pkt_done      = 1'b0;
        w_stall         = 1'b0;
        case (r_state)
            SEL: begin
                w_bus_ready_nxt = 1'b0;
                if (w_found) begin
                    w_set_busy      = NUM_TURBO'(1) << w_grant;
                    w_cur_nxt       = w_grant;
                    w_rr_nxt        = w_grant;
                    w_bus_ready_nxt = 1'b1;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = XFER;
                end else begin
                    w_stall = 1'b1;
                end
            end
            XFER: begin
                if (w_beat) begin
                    if (r_cnt == C_LAST) begin
                        w_bus_ready_nxt = 1'b0;
                        w_cnt_nxt       = '0;
                        w_pkt_done      = 1'b1;
                        w_state_nxt     = SEL;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt     = SEL;
                w_bus_ready_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_bus) begin
        if (!rst_n) begin
            r_state     <= SEL;
            r_bus_ready <= 1'b0;
            r_cnt       <= '0;
            r_rr        <= IDX_W'(NUM_TURBO - 1);
            r_cur_lane  <= '0;
            r_busy      <= '0;
            r_lane_en   <= '0;
            r_lane_data <= '0;
            r_err       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_bus_ready <= w_bus_ready_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rr        <= w_rr_nxt;
            r_cur_lane  <= w_cur_nxt;
            r_busy      <= (r_busy & ~lane_done) | w_set_busy;
            r_lane_en   <= w_beat ? (NUM_TURBO'(1) << r_cur_lane) : '0;
            if (w_beat) begin
                r_lane_data <= in_data;
            end
            // Early completion of the active lane is flagged but the packet is still streamed.
            r_err[0] <= r_err[0] | (in_en & ~r_bus_ready);
            r_err[1] <= r_err[1] | ((r_state == XFER) & lane_done[r_cur_lane] & r_busy[r_cur_lane]);
        end
    end

    assign bus_ready = r_bus_ready;
    assign lane_data = r_lane_data;
    assign lane_en   = r_lane_en;
    assign cur_lane  = r_cur_lane;
    assign lane_busy = r_busy;
    assign err_flags = r_err;

`ifdef TURBO_SCHED_STATS_EN
    logic [31:0] r_pkt_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_bus) begin
        if (!rst_n) begin
            r_pkt_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_pkt_done) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign pkt_cnt   = r_pkt_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_turbo_dispatch_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_turbo_dispatch_sched
// Purpose  : Scoreboard bench for turbo_dispatch_sched with a packet-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_turbo_dispatch_sched;

    localparam int NT  = 16;
    localparam int IW  = 4;
    localparam int BW  = 534;
    localparam int BPP = 25;

    logic          clk_bus = 1'b0;
    logic          rst_n   = 1'b0;
    logic [BW-1:0] in_data = '0;
    logic          in_en   = 1'b0;
    logic          bus_ready;
    logic [BW-1:0] lane_data;
    logic [NT-1:0] lane_en;
    logic [NT-1:0] lane_ready = '0;
    logic [NT-1:0] lane_done  = '0;
    logic [IW-1:0] cur_lane;
    logic [NT-1:0] lane_busy;
    logic [1:0]    err_flags;
`ifdef TURBO_SCHED_STATS_EN
    logic [31:0]   pkt_cnt;
    logic [31:0]   stall_cnt;
`endif

    turbo_dispatch_sched #(
        .NUM_TURBO(NT), .IDX_W(IW), .BUS(BW), .BEATS_PER_PKT(BPP)
    ) dut (
        .clk_bus(clk_bus), .rst_n(rst_n), .in_data(in_data), .in_en(in_en),
        .bus_ready(bus_ready), .lane_data(lane_data), .lane_en(lane_en),
        .lane_ready(lane_ready), .lane_done(lane_done), .cur_lane(cur_lane),
        .lane_busy(lane_busy), .err_flags(err_flags)
`ifdef TURBO_SCHED_STATS_EN
        , .pkt_cnt(pkt_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk_bus = ~clk_bus;

    int cyc = 0;
    always @(posedge clk_bus) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        int            lane;
        logic [BW-1:0] data;
    } beat_t;

    beat_t         sb_q[$];
    beat_t         mon_e;
    bit            mon_on = 1'b0;
    int            n_chk  = 0;
    int            n_pass = 0;

    // Packet-level reference state
    logic [NT-1:0] m_busy;
    int            m_rr;
    int            m_cur;
    logic [1:0]    m_err;
    int            m_pkts;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Scoreboard monitor: each cycle either the expected beat or silence.
    always @(negedge clk_bus) begin
        if (mon_on) begin
            if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                mon_e = sb_q.pop_front();
                chk("beat_missed", 64'(mon_e.cyc), 64'(cyc));
            end
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                mon_e = sb_q.pop_front();
                chk("lane_en_beat", 64'(lane_en), 64'(NT'(1) << mon_e.lane));
                n_chk++;
                if (lane_data === mon_e.data) n_pass++;
                else $display("FAIL lane_data: got 0x%0h expected 0x%0h", lane_data, mon_e.data);
            end else begin
                chk("lane_en_idle", 64'(lane_en), 64'h0);
            end
        end
    end

    function automatic int model_pick(input logic [NT-1:0] rdy);
        for (int k = 1; k <= NT; k++) begin
            int i;
            i = (m_rr + k) % NT;
            if (rdy[i] && !m_busy[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [BW-1:0] rnd_data();
        logic [BW-1:0] d;
        d = '0;
        for (int w = 0; w < 17; w++) d = {d[BW-33:0], 32'($urandom)};
        return d;
    endfunction

    task automatic step();
        @(posedge clk_bus);
        #1;
    endtask

    task automatic model_done(input logic [NT-1:0] mask, input bit in_xfer);
        if (in_xfer && mask[m_cur] && m_busy[m_cur]) m_err[1] = 1'b1;
        m_busy = m_busy & ~mask;
    endtask

    task automatic model_reset();
        m_busy = '0; m_rr = NT - 1; m_cur = 0; m_err = '0; m_pkts = 0;
        sb_q.delete();
    endtask

    task automatic pulse_done(input logic [NT-1:0] mask);
        lane_done = mask;
        model_done(mask, 1'b0);
        step();
        lane_done = '0;
    endtask

    task automatic send_packet(input logic [NT-1:0] rdy, input int gap_pct, input int done_beat,
                               input logic [NT-1:0] done_mask, input int abort_at);
        int g;
        int b;
        int tmo;
        logic [BW-1:0] d;
        g = model_pick(rdy);
        lane_ready = rdy;
        in_en = 1'b0;
        tmo = 0;
        do begin
            step();
            tmo++;
        end while (bus_ready !== 1'b1 && tmo < 8);
        lane_ready = '0;
        chk("grant_latency", 64'(tmo), 64'd1);
        if (bus_ready !== 1'b1) return;
        m_busy[g] = 1'b1;
        m_rr = g;
        m_cur = g;
        chk("cur_lane_grant", 64'(cur_lane), 64'(g));
        chk("busy_grant", 64'(lane_busy), 64'(m_busy));
        b = 0;
        while (b < BPP) begin
            if (abort_at >= 0 && b == abort_at) begin
                in_en = 1'b0;
                return;
            end
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                in_en = 1'b0;
            end else begin
                d = rnd_data();
                in_data = d;
                in_en = 1'b1;
                sb_q.push_back('{cyc + 1, g, d});
                if (b == done_beat) begin
                    lane_done = done_mask;
                    model_done(done_mask, 1'b1);
                end
                b++;
            end
            step();
            lane_done = '0;
        end
        in_en = 1'b0;
        m_pkts++;
        chk("bus_ready_end", 64'(bus_ready), 64'h0);
        chk("busy_end", 64'(lane_busy), 64'(m_busy));
        chk("err_end", 64'(err_flags), 64'(m_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NT-1:0] mask;
        logic [NT-1:0] rdy;

        model_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        mon_on = 1'b1;
        chk("rst_bus_ready", 64'(bus_ready), 64'h0);
        chk("rst_busy", 64'(lane_busy), 64'h0);
        chk("rst_err", 64'(err_flags), 64'h0);
        chk("rst_cur_lane", 64'(cur_lane), 64'h0);
`ifdef TURBO_SCHED_STATS_EN
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'h0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'h0);
`endif

        // Three contiguous packets with every lane ready
        for (int p = 0; p < 3; p++) begin
            send_packet(16'hFFFF, 0, -1, '0, -1);
            chk("rr_seq_lane", 64'(cur_lane), 64'(p));
        end
        chk("busy_three", 64'(lane_busy), 64'h0007);

        // Single ready lane, then starvation
        pulse_done(16'h0007);
        send_packet(16'h0010, 0, -1, '0, -1);
        chk("grant_lane4", 64'(cur_lane), 64'd4);
        begin
`ifdef TURBO_SCHED_STATS_EN
            logic [31:0] s0;
            s0 = stall_cnt;
`endif
            for (int i = 0; i < 5; i++) begin
                step();
                chk("stall_bus_ready", 64'(bus_ready), 64'h0);
            end
`ifdef TURBO_SCHED_STATS_EN
            chk("stall_cnt_delta", 64'(stall_cnt - s0), 64'd5);
`endif
        end

        // Beat offered while not ready
        in_data = rnd_data();
        in_en = 1'b1;
        m_err[0] = 1'b1;
        step();
        in_en = 1'b0;
        step();
        chk("err_drop", 64'(err_flags), 64'h1);
        chk("drop_bus_ready", 64'(bus_ready), 64'h0);
        chk("drop_cur_lane", 64'(cur_lane), 64'd4);

        // Round-robin wrap from lane 15 to lane 0
        pulse_done(16'h0010);
        send_packet(16'h8000, 0, -1, '0, -1);
        chk("grant_lane15", 64'(cur_lane), 64'd15);
        pulse_done(16'h8000);
        send_packet(16'h8001, 0, -1, '0, -1);
        chk("wrap_lane0", 64'(cur_lane), 64'd0);

        // Active lane reports done mid-packet
        send_packet(16'h0002, 0, 10, 16'h0002, -1);
        chk("early_done_err", 64'(err_flags), 64'h3);
        chk("early_done_busy", 64'(lane_busy), 64'h0001);

        // Randomized traffic
        for (int p = 0; p < 10; p++) begin
            mask = NT'($urandom);
            if ((m_busy & ~mask) == '1) mask[$urandom_range(0, NT - 1)] = 1'b1;
            pulse_done(mask);
            rdy = NT'($urandom);
            if ((rdy & ~m_busy) == '0) rdy = ~m_busy;
            send_packet(rdy, 30, $urandom_range(0, BPP - 1), NT'($urandom), -1);
        end
`ifdef TURBO_SCHED_STATS_EN
        chk("pkt_cnt", 64'(pkt_cnt), 64'(m_pkts));
`endif

        // Reset in the middle of a packet
        pulse_done('1);
        send_packet(16'hFFFF, 0, -1, '0, 12);
        rst_n = 1'b0;
        step();
        model_reset();
        chk("midrst_bus_ready", 64'(bus_ready), 64'h0);
        chk("midrst_lane_en", 64'(lane_en), 64'h0);
        chk("midrst_busy", 64'(lane_busy), 64'h0);
        chk("midrst_err", 64'(err_flags), 64'h0);
        rst_n = 1'b1;
        send_packet(16'hFFFF, 0, -1, '0, -1);
        chk("post_rst_lane0", 64'(cur_lane), 64'd0);
        step();
        step();
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
